formation_mover: RTL

Position controller for the alien formation's bounding rectangle. Once per video frame it decides whether the formation advances, computes the next top-left corner (horizontal march, edge drop, direction reversal) and drives the registered `topLeftX`/`topLeftY` consumed by the formation's rectangle hit-test and drawing logic. Step rate scales with the number of surviving aliens. The block also flags when the formation reaches the player line.

---
 rtl/formation_mover_if.sv | 23 ++
 rtl/formation_mover.sv | 110 +++++++++++
 2 files changed

// File: rtl/formation_mover_if.sv
// Control inputs and position outputs shared by the formation mover and the
// logic that consumes the formation rectangle.
interface formation_mover_if;
  logic               startOfFrame;
  logic               enable;
  logic               restart;
  logic [5:0]         aliveCount;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               direction;
  logic               stepPulse;
  logic               reachedBottom;

  modport master (
    output startOfFrame, enable, restart, aliveCount,
    input  topLeftX, topLeftY, direction, stepPulse, reachedBottom
  );

  modport slave (
    input  startOfFrame, enable, restart, aliveCount,
    output topLeftX, topLeftY, direction, stepPulse, reachedBottom
  );
endinterface

// File: rtl/formation_mover.sv
// Once-per-frame march/drop controller for the alien formation's top-left
// corner; step rate follows the surviving alien count.
module formation_mover #(
  parameter int INIT_X       = 32,
  parameter int INIT_Y       = 48,
  parameter int FORM_WIDTH   = 256,
  parameter int STEP_X       = 8,
  parameter int STEP_Y       = 16,
  parameter int LEFT_LIMIT   = 0,
  parameter int RIGHT_LIMIT  = 640,
  parameter int BOTTOM_LIMIT = 400,
  parameter int PERIOD_MIN   = 2,
  parameter int PERIOD_MAX   = 30
) (
  input  logic              clk,
  input  logic              reset,
  formation_mover_if.slave  bus
);

  typedef enum logic {MARCH, LANDED} state_t;

  localparam logic signed [12:0] INIT_X_S = 13'(INIT_X);
  localparam logic signed [12:0] INIT_Y_S = 13'(INIT_Y);
  localparam logic signed [12:0] WIDTH_S  = 13'(FORM_WIDTH);
  localparam logic signed [12:0] STEPX_S  = 13'(STEP_X);
  localparam logic signed [12:0] STEPY_S  = 13'(STEP_Y);
  localparam logic signed [12:0] LEFT_S   = 13'(LEFT_LIMIT);
  localparam logic signed [12:0] RIGHT_S  = 13'(RIGHT_LIMIT);
  localparam logic signed [12:0] BOTTOM_S = 13'(BOTTOM_LIMIT);

  state_t             state_q;
  logic signed [10:0] x_q, y_q;
  logic               dir_q, pulse_q, bottom_q;
  logic [4:0]         cnt_q;

  logic [4:0]         period;
  logic               frame_due, step_due, drop;
  logic signed [12:0] x_ext, y_ext, x_step_d, y_drop_d;

  // Period is the alive count clamped into the legal frame range.
  always_comb begin
    period = bus.aliveCount[4:0];
    if (bus.aliveCount < 6'(PERIOD_MIN))
      period = 5'(PERIOD_MIN);
    else if (bus.aliveCount > 6'(PERIOD_MAX))
      period = 5'(PERIOD_MAX);
  end

  assign frame_due = (state_q == MARCH) && bus.startOfFrame && bus.enable &&
                     (bus.aliveCount != 6'd0);
  assign step_due  = frame_due && (cnt_q >= period - 5'd1);

  // 13-bit signed intermediates keep the edge tests free of wrap-around.
  assign x_ext    = 13'(x_q);
  assign y_ext    = 13'(y_q);
  assign x_step_d = dir_q ? x_ext + STEPX_S : x_ext - STEPX_S;
  assign y_drop_d = y_ext + STEPY_S;
  assign drop     = dir_q ? (x_ext + STEPX_S + WIDTH_S > RIGHT_S)
                          : (x_ext - STEPX_S < LEFT_S);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MARCH;
      x_q      <= 11'(INIT_X_S);
      y_q      <= 11'(INIT_Y_S);
      dir_q    <= 1'b1;
      pulse_q  <= 1'b0;
      bottom_q <= 1'b0;
      cnt_q    <= 5'd0;
    end else if (bus.restart) begin
      state_q  <= MARCH;
      x_q      <= 11'(INIT_X_S);
      y_q      <= 11'(INIT_Y_S);
      dir_q    <= 1'b1;
      pulse_q  <= 1'b0;
      bottom_q <= 1'b0;
      cnt_q    <= 5'd0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        MARCH: begin
          if (step_due) begin
            cnt_q   <= 5'd0;
            pulse_q <= 1'b1;
            if (drop) begin
              y_q   <= 11'(y_drop_d);
              dir_q <= ~dir_q;
              if (y_drop_d >= BOTTOM_S) begin
                bottom_q <= 1'b1;
                state_q  <= LANDED;
              end
            end else begin
              x_q <= 11'(x_step_d);
            end
          end else if (frame_due) begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        default: ;  // LANDED: frozen until restart
      endcase
    end
  end

  assign bus.topLeftX      = x_q;
  assign bus.topLeftY      = y_q;
  assign bus.direction     = dir_q;
  assign bus.stepPulse     = pulse_q;
  assign bus.reachedBottom = bottom_q;

endmodule
